// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns single-word register commands into AXI4-Lite
// read/write transactions, one outstanding, with a held response and error count.
module axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [7:0]                    err_count,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [31:0]                   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp
);

  // state   | meaning
  // IDLE    | waiting for a command, cmd_ready high
  // WR_REQ  | AW and W offered, each retires independently
  // WR_RESP | bready high, waiting for B
  // RD_REQ  | AR offered until arready
  // RD_DATA | rready high, waiting for R
  // RSP     | response held until rsp_ready
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(C_M_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [2:0]                    state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          arvalid_q;
  logic                          aw_done;
  logic                          w_done;

  assign cmd_ready     = (state == IDLE);
  assign rsp_valid     = (state == RSP);
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_rready  = (state == RD_DATA);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr & ALIGN_MASK;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            rsp_write <= cmd_write;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)          state     <= WR_RESP;
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            rsp_resp  <= m_axi_bresp;
            rsp_rdata <= '0;
            if (m_axi_bresp != 2'b00 && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            state <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            rsp_resp  <= m_axi_rresp;
            rsp_rdata <= m_axi_rdata;
            if (m_axi_rresp != 2'b00 && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            state <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: latency, skewed handshakes, backpressure,
// error counting/saturation and asynchronous reset mid-transaction.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  err_count;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = '0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_master #(.C_M_AXI_ADDR_WIDTH(32)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are checked and inputs changed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    bvalid = 1'b1; bresp = r;
    step();
    bvalid = 1'b0;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_resp", 32'(rsp_resp), 32'(r));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    arready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rvalid = 1'b1; rdata = d; rresp = r;
    step();
    rvalid = 1'b0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, d);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, 1'b0}, 32'd0);
    chk("rst_readies", {30'd0, bready, rready}, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // write, always-ready slave, best-case latency
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'hFF; cmd_wstrb = 4'hF;
    awready = 1'b1; wready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("w1_awvalid", 32'(awvalid), 32'd1);
    chk("w1_wvalid", 32'(wvalid), 32'd1);
    chk("w1_awaddr", awaddr, 32'h4);
    chk("w1_wdata", wdata, 32'hFF);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_awprot", 32'(awprot), 32'd0);
    chk("w1_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("w1_aw_drop", 32'(awvalid), 32'd0);
    chk("w1_w_drop", 32'(wvalid), 32'd0);
    chk("w1_bready", 32'(bready), 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("w1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("w1_rsp_write", 32'(rsp_write), 32'd1);
    chk("w1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("w1_rsp_rdata", rsp_rdata, 32'd0);
    chk("w1_bready_off", 32'(bready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("w1_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("w1_rsp_valid_off", 32'(rsp_valid), 32'd0);

    // read returning DEADBEEF
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; arready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("r1_arvalid", 32'(arvalid), 32'd1);
    chk("r1_araddr", araddr, 32'h8);
    chk("r1_arprot", 32'(arprot), 32'd0);
    chk("r1_rready_early", 32'(rready), 32'd0);
    step();
    chk("r1_ar_drop", 32'(arvalid), 32'd0);
    chk("r1_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    chk("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("r1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("r1_rsp_resp", 32'(rsp_resp), 32'd0);
    chk("r1_rsp_write", 32'(rsp_write), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // skewed write: wready after 1 cycle, awready after 3
    awready = 1'b0; wready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h1234; cmd_wstrb = 4'h3;
    step();
    cmd_valid = 1'b0;
    chk("sk_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
    step();
    chk("sk_both_valid2", {30'd0, awvalid, wvalid}, 32'd3);
    wready = 1'b1;
    step();
    wready = 1'b0;
    chk("sk_w_drop", 32'(wvalid), 32'd0);
    chk("sk_aw_hold", 32'(awvalid), 32'd1);
    chk("sk_bready_lo", 32'(bready), 32'd0);
    step();
    chk("sk_aw_hold2", 32'(awvalid), 32'd1);
    chk("sk_awaddr", awaddr, 32'h10);
    chk("sk_bready_lo2", 32'(bready), 32'd0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("sk_aw_drop", 32'(awvalid), 32'd0);
    chk("sk_bready", 32'(bready), 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    chk("sk_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // response backpressure with a second command waiting
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; arready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    rvalid = 1'b1; rdata = 32'h5555AAAA; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h24;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h5555AAAA);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_arvalid", 32'(arvalid), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
    chk("bp_not_taken_yet", 32'(arvalid), 32'd0);
    chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bp_second_arvalid", 32'(arvalid), 32'd1);
    chk("bp_second_araddr", araddr, 32'h24);
    step();
    rvalid = 1'b1; rdata = 32'h0; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // error counting and saturation
    chk("err_start", 32'(err_count), 32'd0);
    for (int i = 0; i < 3; i++) do_write(32'h40, 32'hA5A5_0000 + 32'(i), 2'b10);
    do_read(32'h44, 32'h0000_1111, 2'b00);
    chk("err_three", 32'(err_count), 32'd3);
    do_write(32'h48, 32'h0, 2'b00);
    chk("err_okay_hold", 32'(err_count), 32'd3);
    for (int i = 0; i < 251; i++) do_write(32'h4C, 32'h0, 2'b10);
    chk("err_254", 32'(err_count), 32'd254);
    do_read(32'h50, 32'hCAFE_F00D, 2'b11);
    chk("err_255", 32'(err_count), 32'd255);
    do_write(32'h54, 32'h0, 2'b11);
    chk("err_sat", 32'(err_count), 32'd255);

    // asynchronous reset mid-read
    arready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    step();
    cmd_valid = 1'b0;
    chk("rr_arvalid", 32'(arvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_arvalid_async", 32'(arvalid), 32'd0);
    chk("rr_err_cleared", 32'(err_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rr_arvalid_idle", 32'(arvalid), 32'd0);
    arready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hB;
    step();
    cmd_valid = 1'b0;
    chk("rr_unaligned_araddr", araddr, 32'h8);
    step();
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    chk("rr_rsp_rdata", rsp_rdata, 32'h0BAD_0BAD);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
